// File: rtl/bus_cycle_ctrl_if.sv
// Request-side and pad-side signals of the multiplexed bus cycle controller.
// master = controller side, slave = requesters plus pad ring.
interface bus_cycle_ctrl_if #(
    parameter int AW  = 16,
    parameter int SW  = 4,
    parameter int DW  = 16,
    parameter int NCH = 2
);
    logic                  ready;
    logic                  ale;
    logic                  m_ioN;
    logic                  dt_rN;
    logic [DW/8-1:0]       be_n;
    logic                  denN;
    logic                  rdN;
    logic                  wrN;
    logic [DW-1:0]         ad_out;
    logic                  ad_oe;
    logic [DW-1:0]         ad_in;
    logic [SW-1:0]         as_out;
    logic [NCH-1:0]        req;
    logic [NCH*AW-1:0]     addr_off;
    logic [NCH*SW-1:0]     addr_seg;
    logic [NCH*DW-1:0]     wdata;
    logic [NCH*DW/8-1:0]   be;
    logic [NCH-1:0]        mio;
    logic [NCH-1:0]        wr;
    logic [NCH-1:0]        gnt;
    logic [NCH-1:0]        done;
    logic [DW-1:0]         rdata;
    logic                  err;
    logic                  busy;

    modport master (
        input  ready, ad_in, req, addr_off, addr_seg, wdata, be, mio, wr,
        output ale, m_ioN, dt_rN, be_n, denN, rdN, wrN, ad_out, ad_oe, as_out,
               gnt, done, rdata, err, busy
    );

    modport slave (
        output ready, ad_in, req, addr_off, addr_seg, wdata, be, mio, wr,
        input  ale, m_ioN, dt_rN, be_n, denN, rdN, wrN, ad_out, ad_oe, as_out,
               gnt, done, rdata, err, busy
    );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// Round-robin multi-channel 8086-style bus cycle sequencer; done 4 clocks after gnt plus one per TW.
// Backpressure: requesters hold req until gnt; external ready stretches T3 into TW up to TIMEOUT.
module bus_cycle_ctrl #(
    parameter int AW      = 16,
    parameter int SW      = 4,
    parameter int DW      = 16,
    parameter int NCH     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    bus_cycle_ctrl_if.master bus
);
    localparam int BW  = DW / 8;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TCW = $clog2(TIMEOUT + 2);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_TW   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;

    logic [2:0]     state_q, state_d;
    logic [TCW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0]  last_q, last_d;

    logic [CW-1:0]  p_ch_q, p_ch_d;
    logic [AW-1:0]  p_addr_q, p_addr_d;
    logic [SW-1:0]  p_seg_q, p_seg_d;
    logic [DW-1:0]  p_wdata_q, p_wdata_d;
    logic [BW-1:0]  p_be_q, p_be_d;
    logic           p_mio_q, p_mio_d;
    logic           p_wr_q, p_wr_d;

    logic           ale_q, ale_d;
    logic           m_ion_q, m_ion_d;
    logic           dt_rn_q, dt_rn_d;
    logic [BW-1:0]  be_n_q, be_n_d;
    logic           den_n_q, den_n_d;
    logic           rd_n_q, rd_n_d;
    logic           wr_n_q, wr_n_d;
    logic [DW-1:0]  ad_out_q, ad_out_d;
    logic           ad_oe_q, ad_oe_d;
    logic [SW-1:0]  as_out_q, as_out_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [NCH-1:0] done_q, done_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;

    logic           pick_vld;
    logic [CW-1:0]  pick_idx;
    logic           grant, finish, abort, strobe;

    // Search starts one past the last granted channel, so a lone requester is never skipped.
    always_comb begin
        int c;
        c        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 1; i <= NCH; i++) begin
            c = (int'(last_q) + i) % NCH;
            if (!pick_vld && bus.req[c]) begin
                pick_vld = 1'b1;
                pick_idx = CW'(c);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        abort   = 1'b0;
        grant   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|gnt_q) state_d = S_T1;
                else        grant   = pick_vld;
            end
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: begin
                if (bus.ready) begin
                    state_d = S_T4;
                end else begin
                    state_d = S_TW;
                    wcnt_d  = '0;
                end
            end
            S_TW: begin
                if (bus.ready) begin
                    state_d = S_T4;
                end else begin
                    wcnt_d = wcnt_q + TCW'(1);
                    if (TIMEOUT != 0 && wcnt_d == TCW'(TIMEOUT)) begin
                        state_d = S_T4;
                        abort   = 1'b1;
                    end
                end
            end
            S_T4:    state_d = (|gnt_q) ? S_T1 : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Next grant is decided on the edge into T4 so it overlaps the closing cycle.
        finish = (state_q == S_T3 || state_q == S_TW) && state_d == S_T4;
        if (finish) grant = pick_vld;

        last_d    = last_q;
        p_ch_d    = p_ch_q;
        p_addr_d  = p_addr_q;
        p_seg_d   = p_seg_q;
        p_wdata_d = p_wdata_q;
        p_be_d    = p_be_q;
        p_mio_d   = p_mio_q;
        p_wr_d    = p_wr_q;
        gnt_d     = '0;
        if (grant) begin
            gnt_d[pick_idx] = 1'b1;
            last_d    = pick_idx;
            p_ch_d    = pick_idx;
            p_addr_d  = bus.addr_off[int'(pick_idx)*AW +: AW];
            p_seg_d   = bus.addr_seg[int'(pick_idx)*SW +: SW];
            p_wdata_d = bus.wdata[int'(pick_idx)*DW +: DW];
            p_be_d    = bus.be[int'(pick_idx)*BW +: BW];
            p_mio_d   = bus.mio[pick_idx];
            p_wr_d    = bus.wr[pick_idx];
        end

        // p_ch_q still names the finishing channel even when a new grant lands this edge.
        done_d  = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        if (finish) begin
            done_d[p_ch_q] = 1'b1;
            err_d          = abort;
            if (abort)        rdata_d = '1;
            else if (!p_wr_q) rdata_d = bus.ad_in;
        end

        strobe   = (state_d == S_T2) || (state_d == S_T3) || (state_d == S_TW);
        busy_d   = (state_d != S_IDLE);
        ale_d    = (state_d == S_T1);
        as_out_d = (state_d == S_T1) ? p_seg_q : '0;
        den_n_d  = !strobe;
        rd_n_d   = !(strobe && !p_wr_q);
        wr_n_d   = !(strobe && p_wr_q);
        ad_oe_d  = (state_d == S_T1) || (strobe && p_wr_q);

        ad_out_d = ad_out_q;
        if (state_d == S_T1)                ad_out_d = DW'(p_addr_q);
        else if (state_d == S_T2 && p_wr_q) ad_out_d = p_wdata_q;

        m_ion_d = m_ion_q;
        dt_rn_d = dt_rn_q;
        be_n_d  = be_n_q;
        if (state_d == S_T1) begin
            m_ion_d = p_mio_q;
            dt_rn_d = p_wr_q;
            be_n_d  = ~p_be_q;
        end else if (state_d == S_IDLE) begin
            m_ion_d = 1'b1;
            dt_rn_d = 1'b1;
            be_n_d  = '1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            last_q    <= CW'(NCH - 1);
            p_ch_q    <= '0;
            p_addr_q  <= '0;
            p_seg_q   <= '0;
            p_wdata_q <= '0;
            p_be_q    <= '0;
            p_mio_q   <= 1'b0;
            p_wr_q    <= 1'b0;
            ale_q     <= 1'b0;
            m_ion_q   <= 1'b1;
            dt_rn_q   <= 1'b1;
            be_n_q    <= '1;
            den_n_q   <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            ad_out_q  <= '0;
            ad_oe_q   <= 1'b0;
            as_out_q  <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            last_q    <= last_d;
            p_ch_q    <= p_ch_d;
            p_addr_q  <= p_addr_d;
            p_seg_q   <= p_seg_d;
            p_wdata_q <= p_wdata_d;
            p_be_q    <= p_be_d;
            p_mio_q   <= p_mio_d;
            p_wr_q    <= p_wr_d;
            ale_q     <= ale_d;
            m_ion_q   <= m_ion_d;
            dt_rn_q   <= dt_rn_d;
            be_n_q    <= be_n_d;
            den_n_q   <= den_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            ad_out_q  <= ad_out_d;
            ad_oe_q   <= ad_oe_d;
            as_out_q  <= as_out_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.ale    = ale_q;
    assign bus.m_ioN  = m_ion_q;
    assign bus.dt_rN  = dt_rn_q;
    assign bus.be_n   = be_n_q;
    assign bus.denN   = den_n_q;
    assign bus.rdN    = rd_n_q;
    assign bus.wrN    = wr_n_q;
    assign bus.ad_out = ad_out_q;
    assign bus.ad_oe  = ad_oe_q;
    assign bus.as_out = as_out_q;
    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Bench for bus_cycle_ctrl: directed bus-phase checks plus a done scoreboard fed at grant time.
module tb_bus_cycle_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_cycle_ctrl_if #(.AW(16), .SW(4), .DW(16), .NCH(2)) bus ();

    bus_cycle_ctrl #(.AW(16), .SW(4), .DW(16), .NCH(2), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          ch;
        bit          is_rd;
        logic [15:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int ch, input bit w, input bit m, input logic [15:0] a,
                          input logic [3:0] s, input logic [15:0] d, input logic [1:0] b);
        bus.addr_off[ch*16 +: 16] = a;
        bus.addr_seg[ch*4 +: 4]   = s;
        bus.wdata[ch*16 +: 16]    = d;
        bus.be[ch*2 +: 2]         = b;
        bus.wr[ch]                = w;
        bus.mio[ch]               = m;
    endtask

    task automatic expect_txn(input int ch, input bit rd, input logic [15:0] rv,
                              input bit e, input int lat);
        exp_t x;
        x.ch = ch; x.is_rd = rd; x.rdata = rv; x.err = e; x.cyc = cyc + lat;
        sb.push_back(x);
    endtask

    task automatic wait_gnt(input int ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.gnt[ch]) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) chk("gnt_onehot", 32'(bus.gnt), 32'(1) << ch);
        else    chk("gnt_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard: every done must match the oldest outstanding grant.
    always @(negedge clk) begin
        if (reset === 1'b1 && |bus.done) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 32'(bus.done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_ch", 32'(bus.done), 32'(1) << mon_e.ch);
                chk("done_cyc", 32'(cyc), 32'(mon_e.cyc));
                chk("done_err", 32'(bus.err), 32'(mon_e.err));
                if (mon_e.is_rd) chk("rdata", 32'(bus.rdata), 32'(mon_e.rdata));
            end
        end
    end

    initial begin
        bit ok;
        int got;
        int prev;
        reset        = 1'b0;
        bus.ready    = 1'b1;
        bus.req      = '0;
        bus.addr_off = '0;
        bus.addr_seg = '0;
        bus.wdata    = '0;
        bus.be       = '0;
        bus.mio      = '0;
        bus.wr       = '0;
        bus.ad_in    = '0;
        repeat (3) @(negedge clk);

        chk("rst_ctl", 32'({bus.ale, bus.m_ioN, bus.dt_rN, bus.denN, bus.rdN, bus.wrN,
                            bus.ad_oe, bus.busy, bus.err}), 32'b011111000);
        chk("rst_be_n", 32'(bus.be_n), 32'h3);
        chk("rst_ad_out", 32'(bus.ad_out), 32'h0);
        chk("rst_as_out", 32'(bus.as_out), 32'h0);
        chk("rst_gnt_done", 32'({bus.gnt, bus.done}), 32'h0);
        chk("rst_rdata", 32'(bus.rdata), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Channel 0 zero-wait memory read.
        set_ch(0, 1'b0, 1'b1, 16'h1234, 4'h5, 16'h0000, 2'b11);
        bus.req[0] = 1'b1;
        wait_gnt(0, ok);
        bus.req[0] = 1'b0;
        if (ok) begin
            expect_txn(0, 1'b1, 16'hBEEF, 1'b0, 4);
            @(negedge clk);
            chk("rd_t1_ctl", 32'({bus.ale, bus.ad_oe, bus.dt_rN, bus.m_ioN, bus.busy}), 32'b11011);
            chk("rd_t1_ad", 32'(bus.ad_out), 32'h1234);
            chk("rd_t1_as", 32'(bus.as_out), 32'h5);
            chk("rd_t1_be_n", 32'(bus.be_n), 32'h0);
            @(negedge clk);
            chk("rd_t2_ctl", 32'({bus.ale, bus.ad_oe, bus.rdN, bus.wrN, bus.denN}), 32'b00010);
            chk("rd_t2_as", 32'(bus.as_out), 32'h0);
            @(negedge clk);
            chk("rd_t3_rdN", 32'(bus.rdN), 32'd0);
            bus.ad_in = 16'hBEEF;
            @(negedge clk);
            chk("rd_t4_rel", 32'({bus.rdN, bus.denN, bus.ad_oe}), 32'b110);
        end
        drain();

        // Channel 1 I/O write, low byte only.
        set_ch(1, 1'b1, 1'b0, 16'h0042, 4'hA, 16'hA55A, 2'b01);
        bus.req[1] = 1'b1;
        wait_gnt(1, ok);
        bus.req[1] = 1'b0;
        if (ok) begin
            expect_txn(1, 1'b0, 16'h0, 1'b0, 4);
            @(negedge clk);
            chk("wr_t1_ad", 32'(bus.ad_out), 32'h0042);
            chk("wr_t1_as", 32'(bus.as_out), 32'hA);
            @(negedge clk);
            chk("wr_t2_ad", 32'(bus.ad_out), 32'hA55A);
            chk("wr_t2_ctl", 32'({bus.ad_oe, bus.wrN, bus.rdN, bus.denN, bus.m_ioN, bus.dt_rN}),
                32'b101001);
            chk("wr_t2_be_n", 32'(bus.be_n), 32'h2);
        end
        drain();

        // Three wait states.
        set_ch(0, 1'b0, 1'b1, 16'h2000, 4'h1, 16'h0, 2'b11);
        bus.ad_in  = 16'h1357;
        bus.ready  = 1'b0;
        bus.req[0] = 1'b1;
        wait_gnt(0, ok);
        bus.req[0] = 1'b0;
        if (ok) begin
            expect_txn(0, 1'b1, 16'h1357, 1'b0, 7);
            for (int i = 1; i <= 7; i++) begin
                @(negedge clk);
                if (i >= 3 && i <= 6) chk("tw_strobe", 32'({bus.rdN, bus.denN}), 32'b00);
                if (i == 6) bus.ready = 1'b1;
            end
        end
        bus.ready = 1'b1;
        drain();

        // Ready held low until the wait-state timeout aborts the cycle.
        set_ch(1, 1'b0, 1'b1, 16'h3000, 4'h2, 16'h0, 2'b11);
        bus.ad_in  = 16'h5555;
        bus.ready  = 1'b0;
        bus.req[1] = 1'b1;
        wait_gnt(1, ok);
        bus.req[1] = 1'b0;
        if (ok) begin
            expect_txn(1, 1'b1, 16'hFFFF, 1'b1, 19);
            for (int i = 1; i <= 19; i++) begin
                @(negedge clk);
                if (i == 18) chk("to_held", 32'({bus.rdN, bus.denN}), 32'b00);
                if (i == 19) chk("to_release", 32'({bus.rdN, bus.denN, bus.ad_oe, bus.busy}), 32'b1101);
            end
        end
        bus.ready = 1'b1;
        drain();
        @(negedge clk);
        chk("err_one_cycle", 32'(bus.err), 32'd0);

        // Both channels requesting continuously: alternating back-to-back grants.
        set_ch(0, 1'b0, 1'b1, 16'h0100, 4'h1, 16'h0, 2'b11);
        set_ch(1, 1'b1, 1'b1, 16'h0200, 4'h2, 16'h3C3C, 2'b10);
        bus.ad_in = 16'h0F0F;
        bus.req   = 2'b11;
        got  = 0;
        prev = 0;
        for (int i = 0; i < 40 && got < 4; i++) begin
            @(negedge clk);
            if (|bus.gnt) begin
                chk("rr_order", 32'(bus.gnt), (got % 2 == 0) ? 32'd1 : 32'd2);
                if (got > 0) begin
                    chk("b2b_gap", 32'(cyc - prev), 32'd4);
                    chk("b2b_busy", 32'(bus.busy), 32'd1);
                end
                expect_txn(bus.gnt[1] ? 1 : 0, !bus.gnt[1], 16'h0F0F, 1'b0, 4);
                prev = cyc;
                got++;
                if (got == 4) bus.req = 2'b00;
            end
        end
        bus.req = 2'b00;
        chk("rr_count", 32'(got), 32'd4);
        drain();

        // Reset in T2 of a write while channel 1 already has the next request up.
        set_ch(1, 1'b1, 1'b1, 16'h0300, 4'h3, 16'h6996, 2'b11);
        bus.req[1] = 1'b1;
        wait_gnt(1, ok);
        if (ok) begin
            @(negedge clk);
            @(negedge clk);
            chk("rst_t2_wrN", 32'({bus.wrN, bus.ad_oe}), 32'b01);
            #2 reset = 1'b0;
            #1;
            chk("rst_async", 32'({bus.wrN, bus.denN, bus.ad_oe, bus.busy}), 32'b1100);
            @(negedge clk);
            chk("rst_no_done", 32'(bus.done), 32'd0);
            reset = 1'b1;
            wait_gnt(1, ok);
            bus.req[1] = 1'b0;
            if (ok) begin
                expect_txn(1, 1'b0, 16'h0, 1'b0, 4);
                @(negedge clk);
                @(negedge clk);
                chk("regrant_t2_ad", 32'(bus.ad_out), 32'h6996);
            end
        end
        bus.req = 2'b00;
        drain();
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
